// File: rtl/interval_timer_pkg.sv
// Shared definitions for the multi-channel interval timer.
// Holds the per-channel register offsets and the bit positions of the
// CONTROL and STATUS registers. There are no ports.
package interval_timer_pkg;

    // Per-channel register offsets (address[2:0])
    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_CONTROL = 3'd1;
    localparam logic [2:0] REG_PERIOD  = 3'd2;
    localparam logic [2:0] REG_SNAP    = 3'd3;
    localparam logic [2:0] REG_COUNT   = 3'd4;

    // CONTROL bit positions
    localparam int CTL_ITO       = 0;
    localparam int CTL_CONT      = 1;
    localparam int CTL_START     = 2;
    localparam int CTL_STOP      = 3;
    localparam int CTL_PRESC_LSB = 8;
    localparam int CTL_PRESC_MSB = 15;

    // STATUS bit positions
    localparam int ST_TO  = 0;
    localparam int ST_RUN = 1;

endpackage

// File: rtl/interval_timer_channel.sv
// One interval-timer channel: prescaler, down-counter, PERIOD, CONTROL,
// TO/RUN flags and count snapshot.
// Optional feature macro: TIMER_PULSE_OUT_EN (adds pulse_out).
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   wr_status/control/period/snap   decoded write strobes for this channel
//   wdata                           bus write data
//   rd_status/control/period/snap/count  read values, zero-extended to 32 bits
//   irq                             TO & ITO
//   pulse_out                       1-clock pulse after each reload-on-zero (macro only)
module interval_timer_channel
    import interval_timer_pkg::*;
#(
    parameter int          CNT_W        = 32,
    parameter int          PRESC_W      = 8,
    parameter logic [31:0] RESET_PERIOD = 32'd49999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_status,
    input  logic        wr_control,
    input  logic        wr_period,
    input  logic        wr_snap,
    input  logic [31:0] wdata,
    output logic [31:0] rd_status,
    output logic [31:0] rd_control,
    output logic [31:0] rd_period,
    output logic [31:0] rd_snap,
    output logic [31:0] rd_count,
`ifdef TIMER_PULSE_OUT_EN
    output logic        pulse_out,
`endif
    output logic        irq
);

    localparam logic [CNT_W-1:0] RST_VAL = RESET_PERIOD[CNT_W-1:0];

    logic [CNT_W-1:0]   counter;
    logic [CNT_W-1:0]   period;
    logic [CNT_W-1:0]   snap;
    logic [PRESC_W-1:0] presc_cnt;
    logic [PRESC_W-1:0] presc;
    logic               ito;
    logic               cont;
    logic               to;
    logic               run;
    logic               reload_pend;  // PERIOD was written last cycle

    logic               start;
    logic               stop;
    logic               clr_to;
    logic               tick;
    logic               zero;
    logic               timeout;

    assign start   = wr_control & wdata[CTL_START];
    assign stop    = wr_control & wdata[CTL_STOP];
    assign clr_to  = wr_status & wdata[ST_TO];
    assign zero    = (counter == '0);
    // The forced reload after a PERIOD write takes precedence over counting
    assign tick    = run & ~reload_pend & (presc_cnt == '0);
    assign timeout = tick & zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter     <= RST_VAL;
            period      <= RST_VAL;
            snap        <= '0;
            presc_cnt   <= '0;
            presc       <= '0;
            ito         <= 1'b0;
            cont        <= 1'b0;
            to          <= 1'b0;
            run         <= 1'b0;
            reload_pend <= 1'b0;
        end else begin
            if (wr_control) begin
                ito   <= wdata[CTL_ITO];
                cont  <= wdata[CTL_CONT];
                presc <= wdata[CTL_PRESC_LSB +: PRESC_W];
            end

            if (wr_period) begin
                period <= wdata[CNT_W-1:0];
            end
            reload_pend <= wr_period;

            if (wr_snap) begin
                snap <= counter;
            end

            if (reload_pend) begin
                counter   <= period;
                presc_cnt <= presc;
                run       <= 1'b0;
            end else if (tick) begin
                presc_cnt <= presc;
                if (zero) begin
                    counter <= period;
                    if (!cont) begin
                        run <= 1'b0;
                    end
                end else begin
                    counter <= counter - 1'b1;
                end
            end else if (run) begin
                presc_cnt <= presc_cnt - 1'b1;
            end

            // START beats STOP; a START while running leaves the count alone.
            // Later assignments override the counting updates above.
            if (start) begin
                if (!run || reload_pend) begin
                    run       <= 1'b1;
                    presc_cnt <= wdata[CTL_PRESC_LSB +: PRESC_W];
                end
            end else if (stop) begin
                run <= 1'b0;
            end

            // A timeout is never lost to a coincident clear
            if (timeout) begin
                to <= 1'b1;
            end else if (clr_to) begin
                to <= 1'b0;
            end
        end
    end

`ifdef TIMER_PULSE_OUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse_out <= 1'b0;
        end else begin
            pulse_out <= timeout;
        end
    end
`endif

    always_comb begin
        rd_status                              = '0;
        rd_status[ST_TO]                       = to;
        rd_status[ST_RUN]                      = run;
        rd_control                             = '0;
        rd_control[CTL_ITO]                    = ito;
        rd_control[CTL_CONT]                   = cont;
        rd_control[CTL_PRESC_LSB +: PRESC_W]   = presc;
        rd_period                              = 32'(period);
        rd_snap                                = 32'(snap);
        rd_count                               = 32'(counter);
    end

    assign irq = to & ito;

endmodule

// File: rtl/multi_channel_interval_timer.sv
// Multi-channel interval timer behind an Avalon-MM slave.
// Optional feature macro: TIMER_PULSE_OUT_EN (adds pulse_out[NUM_CH-1:0]).
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   address        word address: [ADDR_W-1:3] channel, [2:0] register
//   chipselect     slave select
//   write_n        active-low write
//   writedata      write data
//   readdata       registered read data (1 cycle after address, ungated)
//   irq            OR of irq_vec
//   irq_vec        per-channel interrupt (TO & ITO)
//   pulse_out      per-channel reload pulse (macro only)
module multi_channel_interval_timer
    import interval_timer_pkg::*;
#(
    parameter int          NUM_CH       = 4,
    parameter int          CNT_W        = 32,
    parameter int          PRESC_W      = 8,
    parameter logic [31:0] RESET_PERIOD = 32'd49999,
    parameter int          ADDR_W       = $clog2(NUM_CH) + 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
`ifdef TIMER_PULSE_OUT_EN
    output logic [NUM_CH-1:0] pulse_out,
`endif
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec
);

    logic              wr;
    logic [2:0]        reg_sel;
    logic [ADDR_W-1:0] ch_sel;
    logic [31:0]       rd_next;

    logic [31:0] rd_status  [NUM_CH];
    logic [31:0] rd_control [NUM_CH];
    logic [31:0] rd_period  [NUM_CH];
    logic [31:0] rd_snap    [NUM_CH];
    logic [31:0] rd_count   [NUM_CH];

    assign wr      = chipselect & ~write_n;
    assign reg_sel = address[2:0];
    // Shift keeps this valid for a single channel with no channel field
    assign ch_sel  = address >> 3;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic hit;
        assign hit = wr & (ch_sel == ADDR_W'(i));

        interval_timer_channel #(
            .CNT_W        (CNT_W),
            .PRESC_W      (PRESC_W),
            .RESET_PERIOD (RESET_PERIOD)
        ) u_channel (
            .clk        (clk),
            .reset      (reset),
            .wr_status  (hit & (reg_sel == REG_STATUS)),
            .wr_control (hit & (reg_sel == REG_CONTROL)),
            .wr_period  (hit & (reg_sel == REG_PERIOD)),
            .wr_snap    (hit & (reg_sel == REG_SNAP)),
            .wdata      (writedata),
            .rd_status  (rd_status[i]),
            .rd_control (rd_control[i]),
            .rd_period  (rd_period[i]),
            .rd_snap    (rd_snap[i]),
            .rd_count   (rd_count[i]),
`ifdef TIMER_PULSE_OUT_EN
            .pulse_out  (pulse_out[i]),
`endif
            .irq        (irq_vec[i])
        );
    end

    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == ADDR_W'(i)) begin
                case (reg_sel)
                    REG_STATUS:  rd_next = rd_status[i];
                    REG_CONTROL: rd_next = rd_control[i];
                    REG_PERIOD:  rd_next = rd_period[i];
                    REG_SNAP:    rd_next = rd_snap[i];
                    REG_COUNT:   rd_next = rd_count[i];
                    default:     rd_next = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

    assign irq = |irq_vec;

endmodule

// File: tb/tb_multi_channel_interval_timer.sv
// Self-checking bench for multi_channel_interval_timer. Three channels are
// instantiated so that channel index NUM_CH is addressable. Expected values
// come from closed-form timing: a channel started at edge w with counter c
// and prescaler p holds c - floor((e-w)/(p+1)) after edge e, and a one-shot
// times out (p+1)*(c+1) edges after its START.
module tb_multi_channel_interval_timer;
    import interval_timer_pkg::*;

    localparam int NUM_CH  = 3;
    localparam int CNT_W   = 32;
    localparam int PRESC_W = 8;
    localparam int ADDR_W  = $clog2(NUM_CH) + 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] address = '0;
    logic              chipselect = 1'b0;
    logic              write_n = 1'b1;
    logic [31:0]       writedata = '0;
    logic [31:0]       readdata;
    logic              irq;
    logic [NUM_CH-1:0] irq_vec;
`ifdef TIMER_PULSE_OUT_EN
    logic [NUM_CH-1:0] pulse_out;
`endif

    multi_channel_interval_timer #(
        .NUM_CH       (NUM_CH),
        .CNT_W        (CNT_W),
        .PRESC_W      (PRESC_W),
        .RESET_PERIOD (32'd49999)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
`ifdef TIMER_PULSE_OUT_EN
        .pulse_out  (pulse_out),
`endif
        .irq        (irq),
        .irq_vec    (irq_vec)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int ncmp  = 0;
    int nfail = 0;

    logic [31:0] mperiod [NUM_CH];
    logic [31:0] mctrl   [NUM_CH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] ra(input int ch, input logic [2:0] r);
        return ADDR_W'(ch * 8 + int'(r));
    endfunction

    // Called at a negedge; the write lands on the following posedge.
    task automatic bus_write(input int ch, input logic [2:0] r, input logic [31:0] d);
        address    = ra(ch, r);
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Returns the register state as it stood after the edge at call time.
    task automatic bus_read(input int ch, input logic [2:0] r, output logic [31:0] d);
        address    = ra(ch, r);
        chipselect = 1'b1;
        @(negedge clk);
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_irq(input int ch, input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound; i++) begin
            if (irq_vec[ch]) begin
                at = edge_cnt;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic oneshot(input int ch, input int n, input int p);
        int          w;
        int          at;
        logic [31:0] d;
        bus_write(ch, REG_STATUS, 32'd1);
        bus_write(ch, REG_PERIOD, 32'(n));
        bus_write(ch, REG_CONTROL, 32'(1 | (1 << CTL_START) | (p << CTL_PRESC_LSB)));
        w = edge_cnt;
        mperiod[ch] = 32'(n);
        mctrl[ch]   = 32'(1 | (p << CTL_PRESC_LSB));
        wait_irq(ch, 4000, at);
        check("oneshot_latency", (at < 0) ? 32'hFFFF_FFFF : 32'(at - w), 32'((p + 1) * (n + 1)));
        bus_read(ch, REG_STATUS, d);
        check("oneshot_status", d, 32'd1);
        check("oneshot_irq", {31'd0, irq}, 32'd1);
        bus_read(ch, REG_COUNT, d);
        check("oneshot_reloaded", d, 32'(n));
    endtask

    initial begin
        logic [31:0] d;
        int          w;
        int          s;
        int          e;
        int          frozen;

        for (int i = 0; i < NUM_CH; i++) begin
            mperiod[i] = 32'd49999;
            mctrl[i]   = 32'd0;
        end

        // Reset defaults
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_readdata", readdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_irq_vec", 32'(irq_vec), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        bus_read(0, REG_PERIOD, d);  check("rst_period", d, 32'd49999);
        bus_read(0, REG_COUNT, d);   check("rst_count", d, 32'd49999);
        bus_read(0, REG_STATUS, d);  check("rst_status", d, 32'd0);

        // One-shot with prescaler, then STATUS clear drops irq
        oneshot(1, 9, 3);
        bus_write(1, REG_STATUS, 32'd1);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        bus_read(1, REG_CONTROL, d);
        check("ctrl_readback", d, mctrl[1]);
        repeat (3) begin
            oneshot(1, int'($urandom_range(1, 30)), int'($urandom_range(0, 5)));
            bus_write(1, REG_STATUS, 32'd1);
        end

        // Clear coincident with a timeout: n=5, p=1 times out 12 edges after START
        bus_write(1, REG_STATUS, 32'd1);
        bus_write(1, REG_PERIOD, 32'd5);
        bus_write(1, REG_CONTROL, 32'(1 | (1 << CTL_START) | (1 << CTL_PRESC_LSB)));
        w = edge_cnt;
        mperiod[1] = 32'd5;
        mctrl[1]   = 32'(1 | (1 << CTL_PRESC_LSB));
        while (edge_cnt < w + 11) @(negedge clk);
        bus_write(1, REG_STATUS, 32'd1);
        check("clr_vs_timeout_irq", 32'(irq_vec), 32'b010);
        bus_read(1, REG_STATUS, d);
        check("clr_vs_timeout_to", d, 32'd1);
        bus_write(1, REG_STATUS, 32'd1);

        // Continuous mode on ch2: period 4, prescaler 0 -> reload every 5 clocks
        bus_write(2, REG_PERIOD, 32'd4);
        bus_write(2, REG_CONTROL, 32'((1 << CTL_CONT) | (1 << CTL_START)));
        w = edge_cnt;
        mperiod[2] = 32'd4;
        mctrl[2]   = 32'(1 << CTL_CONT);
        idle(6);
        repeat (6) begin
            idle(int'($urandom_range(0, 7)));
            e = edge_cnt;
            bus_read(2, REG_COUNT, d);
            check("cont_count", d, 32'(4 - ((e - w) % 5)));
        end
        bus_write(2, REG_CONTROL, 32'((1 << CTL_CONT) | (1 << CTL_STOP)));
        s = edge_cnt;
        frozen = 4 - ((s - w) % 5);
        idle(3);
        bus_read(2, REG_COUNT, d);   check("stop_count", d, 32'(frozen));
        idle(7);
        bus_read(2, REG_COUNT, d);   check("stop_count_later", d, 32'(frozen));
        bus_read(2, REG_STATUS, d);  check("stop_status", d, 32'd1);

        // Snapshot and live count on ch0
        bus_write(0, REG_PERIOD, 32'd1000);
        bus_write(0, REG_CONTROL, 32'(1 << CTL_START));
        w = edge_cnt;
        mperiod[0] = 32'd1000;
        idle(int'($urandom_range(3, 50)));
        bus_write(0, REG_SNAP, 32'd0);
        s = edge_cnt;
        idle(int'($urandom_range(1, 40)));
        bus_read(0, REG_SNAP, d);
        check("snap_value", d, 32'(1000 - (s - 1 - w)));
        e = edge_cnt;
        bus_read(0, REG_COUNT, d);
        check("live_count", d, 32'(1000 - (e - w)));

        // START and STOP together: START wins
        bus_write(2, REG_CONTROL, 32'((1 << CTL_CONT) | (1 << CTL_START) | (1 << CTL_STOP)));
        bus_read(2, REG_STATUS, d);
        check("start_stop_run", {31'd0, d[ST_RUN]}, 32'd1);
        bus_read(2, REG_CONTROL, d);
        check("ctrl_strobes_read0", d, mctrl[2]);

        // PERIOD write while running stops the channel and reloads it
        bus_write(2, REG_PERIOD, 32'd77);
        mperiod[2] = 32'd77;
        idle(1);
        bus_read(2, REG_STATUS, d);
        check("period_wr_run", {31'd0, d[ST_RUN]}, 32'd0);
        bus_read(2, REG_COUNT, d);
        check("period_wr_count", d, 32'd77);
        idle(4);
        bus_read(2, REG_COUNT, d);
        check("period_wr_frozen", d, 32'd77);

        // Unmapped registers and channel index NUM_CH
        bus_write(0, 3'd6, 32'hFFFF_FFFF);
        bus_write(0, 3'd7, 32'hFFFF_FFFF);
        bus_write(NUM_CH, REG_PERIOD, 32'h0000_1234);
        bus_write(NUM_CH, REG_CONTROL, 32'h0000_FF03);
        bus_write(NUM_CH, REG_STATUS, 32'hFFFF_FFFF);
        bus_read(0, 3'd6, d);              check("unmapped_reg6", d, 32'd0);
        bus_read(NUM_CH, REG_PERIOD, d);   check("unmapped_ch_period", d, 32'd0);
        bus_read(NUM_CH, REG_COUNT, d);    check("unmapped_ch_count", d, 32'd0);
        for (int i = 0; i < NUM_CH; i++) begin
            bus_read(i, REG_PERIOD, d);    check("keep_period", d, mperiod[i]);
            bus_read(i, REG_CONTROL, d);   check("keep_control", d, mctrl[i]);
        end

        // Asynchronous reset mid-count
        oneshot(1, 2, 0);
        bus_read(0, REG_COUNT, d);
        idle(2);
        #2 reset = 1'b1;
        #1;
        check("async_rst_readdata", readdata, 32'd0);
        check("async_rst_irq", {31'd0, irq}, 32'd0);
        check("async_rst_irq_vec", 32'(irq_vec), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        bus_read(0, REG_COUNT, d);    check("async_rst_count", d, 32'd49999);
        bus_read(1, REG_STATUS, d);   check("async_rst_status", d, 32'd0);
        bus_read(1, REG_CONTROL, d);  check("async_rst_control", d, 32'd0);
        bus_read(2, REG_PERIOD, d);   check("async_rst_period", d, 32'd49999);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
